// File: rtl/gpr_writeback_arbiter_pkg.sv
// Shared types and widths for the GPR write-back broadcast bus.
package gpr_writeback_arbiter_pkg;

    localparam int GPR_RS_ID_W = 5;
    localparam int GPR_ADDR_W  = 5;
    localparam int GPR_DATA_W  = 32;

    typedef struct packed {
        logic [GPR_RS_ID_W-1:0] rs_id;
        logic [GPR_ADDR_W-1:0]  reg_addr;
        logic [GPR_DATA_W-1:0]  result;
    } gpr_wb_packet_t;

endpackage

// File: rtl/gpr_writeback_arbiter_if.sv
// Unit-to-bus request lanes plus the single registered broadcast slot.
interface gpr_writeback_arbiter_if
    import gpr_writeback_arbiter_pkg::*;
#(
    parameter int NUM_UNITS   = 4,
    parameter int RS_ID_WIDTH = 5
);
    localparam int UNIT_W = $clog2(NUM_UNITS);

    logic [NUM_UNITS-1:0]                  req_valid;
    logic [NUM_UNITS-1:0]                  req_ready;
    logic [NUM_UNITS-1:0][RS_ID_WIDTH-1:0] req_rs_id;
    logic [NUM_UNITS-1:0][GPR_ADDR_W-1:0]  req_reg_addr;
    logic [NUM_UNITS-1:0][GPR_DATA_W-1:0]  req_result;

    logic                   out_valid;
    logic                   out_ready;
    logic [RS_ID_WIDTH-1:0] out_rs_id;
    logic [GPR_ADDR_W-1:0]  out_reg_addr;
    logic [GPR_DATA_W-1:0]  out_result;
    logic [UNIT_W-1:0]      out_unit;

    modport master (
        input  req_valid, req_rs_id, req_reg_addr, req_result, out_ready,
        output req_ready, out_valid, out_rs_id, out_reg_addr, out_result,
        output out_unit
    );

    modport slave (
        output req_valid, req_rs_id, req_reg_addr, req_result, out_ready,
        input  req_ready, out_valid, out_rs_id, out_reg_addr, out_result,
        input  out_unit
    );

endinterface

// File: rtl/gpr_writeback_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request after last_grant.
module rr_priority_picker #(
    parameter  int NUM_UNITS = 4,
    localparam int UNIT_W    = $clog2(NUM_UNITS)
) (
    input  logic [NUM_UNITS-1:0] req,
    input  logic [UNIT_W-1:0]    last_grant,
    output logic [NUM_UNITS-1:0] grant,
    output logic [UNIT_W-1:0]    grant_idx,
    output logic                 any_valid
);

    int idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        idx       = 0;
        // offset NUM_UNITS wraps back to last_grant itself, checked last
        for (int off = 1; off <= NUM_UNITS; off++) begin
            idx = (int'(last_grant) + off) % NUM_UNITS;
            if (!any_valid && req[idx]) begin
                any_valid  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = UNIT_W'(idx);
            end
        end
    end

endmodule

// File: rtl/gpr_writeback_arbiter.sv
// Round-robin arbiter feeding one registered GPR write-back broadcast slot.
module gpr_writeback_arbiter
    import gpr_writeback_arbiter_pkg::*;
#(
    parameter int NUM_UNITS   = 4,
    parameter int RS_ID_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    gpr_writeback_arbiter_if.master bus
);

    localparam int UNIT_W = $clog2(NUM_UNITS);

    logic                   out_valid_q, out_valid_d;
    logic [RS_ID_WIDTH-1:0] out_rs_id_q, out_rs_id_d;
    logic [GPR_ADDR_W-1:0]  out_reg_addr_q, out_reg_addr_d;
    logic [GPR_DATA_W-1:0]  out_result_q, out_result_d;
    logic [UNIT_W-1:0]      out_unit_q, out_unit_d;
    logic [UNIT_W-1:0]      last_grant_q, last_grant_d;

    logic                 load_en;
    logic [NUM_UNITS-1:0] grant;
    logic [UNIT_W-1:0]    grant_idx;
    logic                 grant_any;

    rr_priority_picker #(
        .NUM_UNITS (NUM_UNITS)
    ) u_picker (
        .req        (bus.req_valid),
        .last_grant (last_grant_q),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .any_valid  (grant_any)
    );

    // slot is free or being drained this cycle
    assign load_en       = !out_valid_q || bus.out_ready;
    assign bus.req_ready = (load_en && !rst) ? grant : '0;

    always_comb begin
        out_valid_d    = out_valid_q;
        out_rs_id_d    = out_rs_id_q;
        out_reg_addr_d = out_reg_addr_q;
        out_result_d   = out_result_q;
        out_unit_d     = out_unit_q;
        last_grant_d   = last_grant_q;
        if (load_en) begin
            out_valid_d = grant_any;
            if (grant_any) begin
                out_rs_id_d    = bus.req_rs_id[grant_idx];
                out_reg_addr_d = bus.req_reg_addr[grant_idx];
                out_result_d   = bus.req_result[grant_idx];
                out_unit_d     = grant_idx;
                last_grant_d   = grant_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q    <= 1'b0;
            out_rs_id_q    <= '0;
            out_reg_addr_q <= '0;
            out_result_q   <= '0;
            out_unit_q     <= '0;
            last_grant_q   <= UNIT_W'(NUM_UNITS - 1);
        end else begin
            out_valid_q    <= out_valid_d;
            out_rs_id_q    <= out_rs_id_d;
            out_reg_addr_q <= out_reg_addr_d;
            out_result_q   <= out_result_d;
            out_unit_q     <= out_unit_d;
            last_grant_q   <= last_grant_d;
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out_rs_id    = out_rs_id_q;
    assign bus.out_reg_addr = out_reg_addr_q;
    assign bus.out_result   = out_result_q;
    assign bus.out_unit     = out_unit_q;

endmodule

// File: tb/tb_gpr_writeback_arbiter.sv
// Scoreboard bench for gpr_writeback_arbiter with a round-robin grant model.
module tb_gpr_writeback_arbiter;
    import gpr_writeback_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int UW = 2;

    typedef struct packed {
        logic [UW-1:0]  unit;
        gpr_wb_packet_t pkt;
    } sb_entry_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gpr_writeback_arbiter_if #(.NUM_UNITS(N), .RS_ID_WIDTH(5)) bus ();

    gpr_writeback_arbiter #(
        .NUM_UNITS   (N),
        .RS_ID_WIDTH (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int        n_cmp = 0;
    int        n_err = 0;
    sb_entry_t sb_q[$];
    logic      m_valid;
    int        m_last;
    logic      rst_prev = 1'b0;
    logic [N-1:0]  acc;
    logic [N-1:0]  cap_rdy;
    logic          cap_valid;
    logic [UW-1:0] cap_unit;
    logic [31:0]   cap_result;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick(logic [N-1:0] v, int last);
        for (int off = 1; off <= N; off++) begin
            if (v[(last + off) % N]) return (last + off) % N;
        end
        return -1;
    endfunction

    task automatic new_data(int u);
        bus.req_rs_id[u]    = 5'($urandom);
        bus.req_reg_addr[u] = 5'($urandom);
        bus.req_result[u]   = $urandom;
    endtask

    task automatic step();
        sb_entry_t    e;
        int           g;
        logic         load;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        acc        = bus.req_ready & bus.req_valid;
        cap_rdy    = bus.req_ready;
        cap_valid  = bus.out_valid;
        cap_unit   = bus.out_unit;
        cap_result = bus.out_result;
        if (rst) begin
            check("rdy_in_rst", 64'(bus.req_ready), 64'd0);
            if (rst_prev)
                check("out_in_rst", {bus.out_valid, bus.out_unit,
                      bus.out_rs_id, bus.out_reg_addr, bus.out_result}, 64'd0);
            m_valid = 1'b0;
            m_last  = N - 1;
            sb_q.delete();
        end else begin
            load    = !m_valid || bus.out_ready;
            g       = load ? pick(bus.req_valid, m_last) : -1;
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
            check("out_valid", 64'(bus.out_valid), 64'(m_valid));
            if (m_valid) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 64'(sb_q.size()), 64'd1);
                end else begin
                    e = bus.out_ready ? sb_q.pop_front() : sb_q[0];
                    check(bus.out_ready ? "slot_drain" : "slot_hold",
                          {bus.out_unit, bus.out_rs_id, bus.out_reg_addr,
                           bus.out_result}, {e.unit, e.pkt});
                end
            end
            if (load) begin
                if (g >= 0) begin
                    e.unit         = UW'(g);
                    e.pkt.rs_id    = bus.req_rs_id[g];
                    e.pkt.reg_addr = bus.req_reg_addr[g];
                    e.pkt.result   = bus.req_result[g];
                    sb_q.push_back(e);
                    m_last  = g;
                    m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
        rst_prev = rst;
        @(posedge clk);
        #1;
        for (int u = 0; u < N; u++) if (acc[u]) new_data(u);
    endtask

    initial begin
        rst           = 1'b1;
        bus.out_ready = 1'b1;
        bus.req_valid = '1;
        for (int u = 0; u < N; u++) new_data(u);
        step();
        step();

        rst = 1'b0;
        step();
        check("first_grant", 64'(cap_rdy), 64'h1);
        for (int i = 0; i < 7; i++) step();

        bus.req_valid = '0;
        step();
        step();
        check("drain_empty", 64'(cap_valid), 64'd0);

        bus.req_rs_id[2]    = 5'h0A;
        bus.req_reg_addr[2] = 5'd7;
        bus.req_result[2]   = 32'hDEADBEEF;
        bus.req_valid       = 4'b0100;
        step();
        check("single_rdy", 64'(cap_rdy), 64'h4);
        bus.req_valid = '0;
        step();
        check("single_unit", 64'(cap_unit), 64'd2);
        check("single_res", 64'(cap_result), 64'hDEADBEEF);

        bus.req_valid = 4'b0010;
        step();
        bus.req_valid = 4'b1001;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_no_rdy", 64'(cap_rdy), 64'd0);
        end
        bus.out_ready = 1'b1;
        step();
        check("bp_grant3", 64'(cap_rdy), 64'h8);
        bus.req_valid = 4'b0001;
        step();
        check("bp_still_valid", 64'(cap_valid), 64'd1);
        bus.req_valid = '0;
        step();
        step();

        bus.req_valid = 4'b0100;
        step();
        bus.req_valid = '0;
        bus.out_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst           = 1'b0;
        bus.req_valid = '1;
        bus.out_ready = 1'b1;
        step();
        check("rst_mid_flush", 64'(cap_valid), 64'd0);
        check("rst_mid_first", 64'(cap_rdy), 64'h1);

        for (int i = 0; i < 60; i++) begin
            for (int u = 0; u < N; u++)
                if (!bus.req_valid[u] || acc[u])
                    bus.req_valid[u] = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        bus.req_valid = '0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("sb_final", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
